sram1rw_arb_ctrl: RTL

- Sequencer and two-requester arbiter in front of one single-port SRAM1RW128x128 macro (7-bit address, 128-bit word).
- Active-low CSB, WEB and OEB; CE tied to `clock` at the parent.
- After reset, zero-fills the array, then grants one read or write per cycle with round-robin fairness.
- Routes read data back to the issuing requester with fixed latency.

---
 rtl/sram1rw_arb_pkg.sv | 26 ++
 rtl/sram1rw_rr_arb2.sv | 45 ++++
 rtl/sram1rw_arb_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sram1rw_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram1rw_arb_pkg
// Shared types and defaults for the SRAM1RW128x128 sequencer/arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default macro geometry (7-bit address, 128-bit word)
//   state_t                 : controller state (ST_INIT zero-fill, ST_RUN service)
//   req_id_t                : requester index (0 or 1)
//   rsp_pipe_t              : one stage of the read-return tracking pipe
// -----------------------------------------------------------------------------
package sram1rw_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 128;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_pipe_t;

endpackage : sram1rw_arb_pkg

// File: rtl/sram1rw_rr_arb2.sv
// -----------------------------------------------------------------------------
// sram1rw_rr_arb2
// Two-input round-robin arbiter. Grant is combinational from valid; the
// priority pointer moves to the other requester whenever a grant is taken,
// so two continuously valid requesters alternate strictly.
// Ports:
//   clock  : clock
//   reset  : synchronous active-high reset (pointer -> requester 0)
//   enable : grants are only issued while high
//   valid  : per-requester request
//   grant  : per-requester grant (at most one bit set)
// -----------------------------------------------------------------------------
module sram1rw_rr_arb2
    import sram1rw_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_id_t ptr_r;

    // Grant: a requester wins if it is alone or currently holds priority.
    always_comb begin
        grant    = 2'b00;
        grant[0] = enable & valid[0] & (~valid[1] | (ptr_r == 1'b0));
        grant[1] = enable & valid[1] & (~valid[0] | (ptr_r == 1'b1));
    end

    // Priority pointer: hand priority to the other requester after a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (grant[0]) begin
            ptr_r <= 1'b1;
        end else if (grant[1]) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule : sram1rw_rr_arb2

// File: rtl/sram1rw_arb_ctrl.sv
// -----------------------------------------------------------------------------
// sram1rw_arb_ctrl
// Sequencer and two-requester arbiter in front of one single-port SRAM1RW
// macro. After reset the whole array is written with INIT_VAL (one word per
// cycle, DEPTH cycles), then one read or write per cycle is granted with
// round-robin fairness. Read data comes back two cycles after the grant and
// is steered to the requester that issued it.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   reqK_valid/ready/we/addr/wdata  : requester K command channel (K = 0,1)
//   rsp0_valid, rsp1_valid          : one-cycle read-return strobes
//   rsp_data                        : read data (shared, straight from mem_o)
//   init_done                       : high once the array has been filled
//   mem_csb/web/oeb/a/i, mem_o      : macro interface (controls active low)
//   perf_grant0/1                   : grant counters, only present when
//                                     SRAM1RW_ARB_PERF_EN is defined
// -----------------------------------------------------------------------------
module sram1rw_arb_ctrl
    import sram1rw_arb_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = 128,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              mem_csb,
    output logic              mem_web,
    output logic              mem_oeb,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] mem_o
`ifdef SRAM1RW_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1
`endif
);

    // One extra counter bit so the final address is seen without wrapping.
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

    state_t            state_r;
    logic [CNT_W-1:0]  init_cnt_r;
    logic [1:0]        grant_s;
    logic              cmd_fire_s;
    req_id_t           cmd_id_s;
    logic              cmd_we_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [DATA_W-1:0] cmd_wdata_s;
    rsp_pipe_t         pipe_s1_r;
    rsp_pipe_t         pipe_s2_r;

    sram1rw_rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (state_r == ST_RUN),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Select the granted requester's command.
    always_comb begin
        cmd_fire_s = grant_s[0] | grant_s[1];
        cmd_id_s   = grant_s[1];
        if (grant_s[1]) begin
            cmd_we_s    = req1_we;
            cmd_addr_s  = req1_addr;
            cmd_wdata_s = req1_wdata;
        end else begin
            cmd_we_s    = req0_we;
            cmd_addr_s  = req0_addr;
            cmd_wdata_s = req0_wdata;
        end
    end

    // Controller FSM and registered macro command stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {CNT_W{1'b0}};
            init_done  <= 1'b0;
            mem_csb    <= 1'b1;
            mem_web    <= 1'b1;
            mem_a      <= {ADDR_W{1'b0}};
            mem_i      <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    mem_csb    <= 1'b0;
                    mem_web    <= 1'b0;
                    mem_a      <= init_cnt_r[ADDR_W-1:0];
                    mem_i      <= INIT_VAL;
                    init_cnt_r <= init_cnt_r + CNT_W'(1);
                    if (init_cnt_r == LAST_CNT) begin
                        state_r   <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        state_r   <= ST_INIT;
                        init_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r    <= ST_RUN;
                    init_cnt_r <= init_cnt_r;
                    init_done  <= 1'b1;
                    if (cmd_fire_s) begin
                        mem_csb <= 1'b0;
                        mem_web <= ~cmd_we_s;
                        mem_a   <= cmd_addr_s;
                        mem_i   <= cmd_wdata_s;
                    end else begin
                        mem_csb <= 1'b1;
                        mem_web <= 1'b1;
                        mem_a   <= mem_a;
                        mem_i   <= mem_i;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= {CNT_W{1'b0}};
                    init_done  <= 1'b0;
                    mem_csb    <= 1'b1;
                    mem_web    <= 1'b1;
                    mem_a      <= {ADDR_W{1'b0}};
                    mem_i      <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // Read-return tracking: stage 1 covers the macro access cycle, stage 2
    // the cycle in which mem_o carries the data.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_s1_r <= '{valid: 1'b0, id: 1'b0};
            pipe_s2_r <= '{valid: 1'b0, id: 1'b0};
        end else begin
            pipe_s1_r.valid <= cmd_fire_s & ~cmd_we_s;
            pipe_s1_r.id    <= cmd_id_s;
            pipe_s2_r       <= pipe_s1_r;
        end
    end

    assign rsp0_valid = pipe_s2_r.valid & (pipe_s2_r.id == 1'b0);
    assign rsp1_valid = pipe_s2_r.valid & (pipe_s2_r.id == 1'b1);
    assign rsp_data   = mem_o;
    assign mem_oeb    = 1'b0;

`ifdef SRAM1RW_ARB_PERF_EN
    // Saturating per-requester grant counters; grants never occur in INIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant0 <= 32'd0;
            perf_grant1 <= 32'd0;
        end else begin
            if (grant_s[0] && (perf_grant0 != 32'hFFFF_FFFF)) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end else begin
                perf_grant0 <= perf_grant0;
            end
            if (grant_s[1] && (perf_grant1 != 32'hFFFF_FFFF)) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end else begin
                perf_grant1 <= perf_grant1;
            end
        end
    end
`endif

endmodule : sram1rw_arb_ctrl
